// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: ZAFx32 PC register and fetch sequencer with buffered redirects
module fetch_pc_unit #(
   parameter logic [0:31] RESET_PC = 32'h0000_0000,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             jump_en,
   input  logic [0:WIDTH-1] jump_target,
   input  logic             branch_taken,
   input  logic [0:WIDTH-1] branch_base,
   input  logic [0:WIDTH-1] branch_offset,
   input  logic             imem_ready,
   output logic             imem_req,
   output logic [0:WIDTH-1] imem_addr,
   output logic [0:WIDTH-1] pc,
   output logic             fetch_valid,
   output logic [0:WIDTH-1] fetched_pc
);
   typedef enum logic [1:0] {BOOT, FETCH, STALL} state_t;
   state_t state, state_nx;
   logic [0:WIDTH-1] pending_target, target, next_pc;
   logic pending_valid, squash, redirect_now, done;
   assign redirect_now = jump_en | branch_taken;
   // branch wins: it is the older instruction
   assign target = branch_taken ? branch_base + WIDTH'(1) + branch_offset : jump_target;
   assign done = (state == FETCH) & imem_ready;
   assign imem_req = state == FETCH;
   assign imem_addr = pc;
   assign next_pc = redirect_now ? target : pending_valid ? pending_target : pc + WIDTH'(1);
   always_comb begin
      state_nx = state;
      state_nx = (state == BOOT) ? FETCH :
                 (state == FETCH) ? ((done & stall) ? STALL : FETCH) :
                 (stall ? STALL : FETCH);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= BOOT;
         pc             <= RESET_PC;
         fetch_valid    <= 1'b0;
         fetched_pc     <= '0;
         pending_valid  <= 1'b0;
         pending_target <= '0;
         squash         <= 1'b0;
      end else begin
         state       <= state_nx;
         fetch_valid <= done & ~(squash | redirect_now | pending_valid);
         if (done) begin
            pc            <= next_pc;
            fetched_pc    <= pc;
            pending_valid <= 1'b0;
            squash        <= 1'b0;
         end else if (state == FETCH && redirect_now && !pending_valid) begin
            // wrong-path fetch in flight: remember target, squash its result
            pending_target <= target;
            pending_valid  <= 1'b1;
            squash         <= 1'b1;
         end else if (state == STALL && redirect_now) begin
            pc <= target;
         end
      end
   end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed vector table plus randomized run against a transaction-level model
module tb_fetch_pc_unit;
   logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, jump_en = 1'b0, branch_taken = 1'b0, imem_ready = 1'b0;
   logic [0:31] jump_target = '0, branch_base = '0, branch_offset = '0;
   logic imem_req, fetch_valid;
   logic [0:31] imem_addr, pc, fetched_pc;
   int total = 0, bad = 0;

   fetch_pc_unit dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .jump_en(jump_en), .jump_target(jump_target),
      .branch_taken(branch_taken), .branch_base(branch_base), .branch_offset(branch_offset),
      .imem_ready(imem_ready), .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc),
      .fetch_valid(fetch_valid), .fetched_pc(fetched_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic st, je; logic [31:0] jt; logic bt; logic [31:0] bb, bo; logic rdy;
      logic e_req; logic [31:0] e_pc; logic e_fv; logic [31:0] e_fpc;
   } vec_t;
   vec_t vecs[$];

   // model: 0 = waiting for first clock, 1 = fetch outstanding, 2 = held
   int m_phase;
   logic [31:0] m_pc, m_fpc;
   logic m_fv;
   logic [31:0] redirq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_pc = 32'h0; m_fpc = 32'h0; m_fv = 1'b0;
      redirq.delete();
   endtask

   task automatic model_edge();
      logic red;
      logic [31:0] tgt;
      red = jump_en | branch_taken;
      tgt = branch_taken ? 32'(branch_base) + 32'd1 + 32'(branch_offset) : 32'(jump_target);
      m_fv = 1'b0;
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1) begin
         if (imem_ready) begin
            m_fv = !red && redirq.size() == 0;
            m_fpc = m_pc;
            m_pc = red ? tgt : (redirq.size() != 0) ? redirq[0] : m_pc + 32'd1;
            redirq.delete();
            m_phase = stall ? 2 : 1;
         end else if (red && redirq.size() == 0) redirq.push_back(tgt);
      end else begin
         if (red) m_pc = tgt;
         if (!stall) m_phase = 1;
      end
   endtask

   task automatic model_check(input string tag);
      chk({tag, "_req"}, 32'(imem_req), 32'(m_phase == 1));
      chk({tag, "_addr"}, imem_addr, m_pc);
      chk({tag, "_pc"}, pc, m_pc);
      chk({tag, "_fv"}, 32'(fetch_valid), 32'(m_fv));
      chk({tag, "_fpc"}, fetched_pc, m_fpc);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      model_check(tag);
   endtask

   task automatic add(input logic st, je, input logic [31:0] jt, input logic bt,
                      input logic [31:0] bb, bo, input logic rdy, input logic e_req,
                      input logic [31:0] e_pc, input logic e_fv, input logic [31:0] e_fpc);
      vec_t v;
      v = '{st, je, jt, bt, bb, bo, rdy, e_req, e_pc, e_fv, e_fpc};
      vecs.push_back(v);
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_req"}, 32'(imem_req), 32'h0);
      chk({tag, "_pc"}, pc, 32'h0);
      chk({tag, "_addr"}, imem_addr, 32'h0);
      chk({tag, "_fv"}, 32'(fetch_valid), 32'h0);
      chk({tag, "_fpc"}, fetched_pc, 32'h0);
   endtask

   initial begin
      //   st je jt            bt bb     bo            rdy req pc            fv fpc
      add(0, 0, 0,            0, 0,     0,            1,  1,  32'h0,        0, 32'h0);
      add(0, 0, 0,            0, 0,     0,            1,  1,  32'h1,        1, 32'h0);
      add(0, 0, 0,            0, 0,     0,            1,  1,  32'h2,        1, 32'h1);
      add(0, 0, 0,            0, 0,     0,            1,  1,  32'h3,        1, 32'h2);
      add(0, 0, 0,            0, 0,     0,            1,  1,  32'h4,        1, 32'h3);
      add(0, 0, 0,            0, 0,     0,            1,  1,  32'h5,        1, 32'h4);
      add(0, 0, 0,            0, 0,     0,            0,  1,  32'h5,        0, 32'h4);
      add(0, 0, 0,            0, 0,     0,            0,  1,  32'h5,        0, 32'h4);
      add(0, 0, 0,            0, 0,     0,            0,  1,  32'h5,        0, 32'h4);
      add(0, 0, 0,            0, 0,     0,            1,  1,  32'h6,        1, 32'h5);
      add(0, 0, 0,            0, 0,     0,            1,  1,  32'h7,        1, 32'h6);
      add(0, 0, 0,            0, 0,     0,            1,  1,  32'h8,        1, 32'h7);
      add(0, 1, 32'hFFFFFC10, 0, 0,     0,            0,  1,  32'h8,        0, 32'h7);
      add(0, 0, 0,            0, 0,     0,            1,  1,  32'hFFFFFC10, 0, 32'h8);
      add(0, 0, 0,            0, 0,     0,            0,  1,  32'hFFFFFC10, 0, 32'h8);
      add(0, 0, 0,            0, 0,     0,            1,  1,  32'hFFFFFC11, 1, 32'hFFFFFC10);
      add(0, 1, 32'h1234,     1, 32'h20, 32'hFFFFFFFC, 1, 1,  32'h1D,       0, 32'hFFFFFC11);
      add(0, 0, 0,            0, 0,     0,            1,  1,  32'h1E,       1, 32'h1D);
      add(0, 0, 0,            1, 32'h3F, 0,           0,  1,  32'h1E,       0, 32'h1D);
      add(0, 1, 32'h80,       0, 0,     0,            0,  1,  32'h1E,       0, 32'h1D);
      add(0, 0, 0,            0, 0,     0,            1,  1,  32'h40,       0, 32'h1E);
      add(1, 0, 0,            0, 0,     0,            0,  1,  32'h40,       0, 32'h1E);
      add(1, 0, 0,            0, 0,     0,            1,  0,  32'h41,       1, 32'h40);
      add(1, 1, 32'hFFFFFFFE, 0, 0,     0,            1,  0,  32'hFFFFFFFE, 0, 32'h40);
      add(0, 0, 0,            0, 0,     0,            0,  1,  32'hFFFFFFFE, 0, 32'h40);
      add(0, 0, 0,            0, 0,     0,            1,  1,  32'hFFFFFFFF, 1, 32'hFFFFFFFE);
      add(1, 0, 0,            0, 0,     0,            1,  0,  32'h0,        1, 32'hFFFFFFFF);
      add(1, 0, 0,            0, 0,     0,            1,  0,  32'h0,        0, 32'hFFFFFFFF);

      model_reset();
      #12;
      reset_check("reset");
      @(negedge clk);
      rst_n = 1'b1;
      foreach (vecs[i]) begin
         stall = vecs[i].st; jump_en = vecs[i].je; jump_target = vecs[i].jt;
         branch_taken = vecs[i].bt; branch_base = vecs[i].bb; branch_offset = vecs[i].bo;
         imem_ready = vecs[i].rdy;
         step($sformatf("vec%0d_model", i));
         chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
         chk($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
         chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_pc);
         chk($sformatf("vec%0d_fv", i), 32'(fetch_valid), 32'(vecs[i].e_fv));
         chk($sformatf("vec%0d_fpc", i), fetched_pc, vecs[i].e_fpc);
      end

      // asynchronous reset in the held state, between clock edges
      #2 rst_n = 1'b0;
      #1 reset_check("async_reset");
      model_reset();
      stall = 1'b0; jump_en = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      for (int c = 0; c < 3000; c++) begin
         stall = ($urandom % 4) == 0;
         jump_en = ($urandom % 7) == 0;
         branch_taken = ($urandom % 7) == 0;
         jump_target = $urandom;
         branch_base = ($urandom % 2) ? 32'($urandom) : 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
         branch_offset = 32'($urandom_range(0, 64)) - 32'd32;
         imem_ready = ($urandom % 3) != 0;
         step($sformatf("rnd%0d", c));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
